// File: rtl/krnl_vadd_rtl_burst_sched.sv
// Burst scheduler for one AXI4 master address channel: splits a (base, beats) job
// into fixed-size bursts, throttles in-flight bursts and pulses ctrl_done when all complete.
module krnl_vadd_rtl_burst_sched #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BYTES_PER_BEAT  = 64,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_beats,
  output logic                         ctrl_done,
  output logic                         busy,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [C_ADDR_WIDTH-1:0]      req_addr,
  output logic [7:0]                   req_len,
  input  logic                         cpl_valid
);

  localparam int OUT_W = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_ADDR_WIDTH-1:0]      BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * C_BYTES_PER_BEAT);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] BURST_BEATS = C_XFER_SIZE_WIDTH'(C_BURST_LEN);
  localparam logic [OUT_W-1:0]             MAX_OUT     = OUT_W'(C_MAX_OUTSTANDING);

  generate
    if (C_BURST_LEN < 1 || C_BURST_LEN > 256 || (C_BURST_LEN & (C_BURST_LEN - 1)) != 0)
      $error("C_BURST_LEN must be a power of 2 in 1..256");
    if (C_BURST_LEN * C_BYTES_PER_BEAT > 4096)
      $error("burst must not cross a 4 KiB boundary");
    if (C_MAX_OUTSTANDING < 1 || C_MAX_OUTSTANDING > 255)
      $error("C_MAX_OUTSTANDING must be in 1..255");
    if (C_XFER_SIZE_WIDTH < 9)
      $error("C_XFER_SIZE_WIDTH must hold at least one full burst length");
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                         state_reg, state_next;
  logic [C_ADDR_WIDTH-1:0]        addr_reg, addr_next;
  logic [C_XFER_SIZE_WIDTH-1:0]   remaining_reg, remaining_next;
  logic [OUT_W-1:0]               outstanding_reg, outstanding_next;
  logic [C_XFER_SIZE_WIDTH-1:0]   burst_beats;
  logic                           handshake;
  logic                           cpl_accept;

  // All request outputs derive from registers only; req_ready/cpl_valid never reach them.
  always_comb begin
    burst_beats = (remaining_reg > BURST_BEATS) ? BURST_BEATS : remaining_reg;
    req_valid   = (state_reg == ISSUE) && (outstanding_reg < MAX_OUT);
    req_addr    = addr_reg;
    req_len     = (state_reg == ISSUE) ? 8'(burst_beats - 1'b1) : 8'd0;
    ctrl_done   = (state_reg == DONE);
    busy        = (state_reg != IDLE);
  end

  assign handshake  = req_valid & req_ready;
  // A completion with nothing in flight is spurious and dropped.
  assign cpl_accept = cpl_valid && (outstanding_reg != '0);

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({handshake, cpl_accept})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (ctrl_start) begin
          addr_next      = ctrl_addr;
          remaining_next = ctrl_xfer_beats;
          state_next     = (ctrl_xfer_beats == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          addr_next      = addr_reg + BURST_BYTES;
          remaining_next = remaining_reg - burst_beats;
          if (remaining_reg == burst_beats)
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Looking at the next count lets the final completion produce done one cycle later.
        if (outstanding_next == '0)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      outstanding_reg <= '0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      remaining_reg   <= remaining_next;
      outstanding_reg <= outstanding_next;
    end
  end

endmodule

// File: tb/tb_krnl_vadd_rtl_burst_sched.sv
// Randomized self-checking bench for krnl_vadd_rtl_burst_sched against a job/burst-list model.
module tb_krnl_vadd_rtl_burst_sched;

  localparam int MAXO = 2;
  localparam int BLEN = 64;
  localparam logic [63:0] BBYTES = 64'd4096;

  logic        clk;
  logic        rst;
  logic        ctrl_start;
  logic [63:0] ctrl_addr;
  logic [31:0] ctrl_xfer_beats;
  logic        ctrl_done;
  logic        busy;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic        cpl_valid;

  krnl_vadd_rtl_burst_sched #(
    .C_ADDR_WIDTH(64), .C_XFER_SIZE_WIDTH(32), .C_BYTES_PER_BEAT(64),
    .C_BURST_LEN(BLEN), .C_MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_xfer_beats(ctrl_xfer_beats), .ctrl_done(ctrl_done), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .cpl_valid(cpl_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: list of bursts still to issue, bursts in flight, job/done flags.
  logic [63:0] q_addr[$];
  int          q_len[$];
  int          m_out;
  bit          job_active;
  bit          done_now;
  int          n_hs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ctrl_start = 1'b0; req_ready = 1'b0; cpl_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_addr.delete(); q_len.delete();
    m_out = 0; job_active = 0; done_now = 0;
    check("rst_addr", req_addr, 64'd0);
    check("rst_len", {56'd0, req_len}, 64'd0);
  endtask

  // Check current outputs, apply inputs for the next edge, advance model and clock.
  task automatic step(input bit st, input logic [63:0] a, input logic [31:0] beats,
                      input bit rdy, input bit cpl);
    bit exp_valid, hs, idle;
    int new_out, rem;
    exp_valid = job_active && (q_addr.size() > 0) && (m_out < MAXO);
    check("req_valid", {63'd0, req_valid}, {63'd0, exp_valid});
    check("busy", {63'd0, busy}, {63'd0, job_active || done_now});
    check("ctrl_done", {63'd0, ctrl_done}, {63'd0, done_now});
    if (exp_valid && req_valid) begin
      check("req_addr", req_addr, q_addr[0]);
      check("req_len", {56'd0, req_len}, 64'(q_len[0]));
    end
    ctrl_start = st; ctrl_addr = a; ctrl_xfer_beats = beats;
    req_ready = rdy; cpl_valid = cpl;
    hs = exp_valid && rdy;
    idle = !job_active && !done_now;
    new_out = m_out + (hs ? 1 : 0) - ((cpl && m_out > 0) ? 1 : 0);
    if (hs) begin
      void'(q_addr.pop_front()); void'(q_len.pop_front());
      n_hs++;
    end
    if (done_now) done_now = 0;
    else if (job_active && q_addr.size() == 0 && new_out == 0) begin
      job_active = 0; done_now = 1;
    end
    if (st && idle) begin
      rem = int'(beats);
      for (int i = 0; rem > 0; i++) begin
        q_addr.push_back(a + BBYTES * 64'(i));
        q_len.push_back(((rem > BLEN) ? BLEN : rem) - 1);
        rem -= BLEN;
      end
      if (beats == 0) done_now = 1; else job_active = 1;
    end
    m_out = new_out;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
  endtask

  task automatic run_to_idle(input int rdy_pct, input int cpl_pct);
    bit rdy, cpl;
    for (int c = 0; c < 4000 && (job_active || done_now); c++) begin
      rdy = ($urandom_range(0, 99) < rdy_pct);
      cpl = (m_out > 0) ? ($urandom_range(0, 99) < cpl_pct) : ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 7) == 0, {$urandom(), $urandom()}, $urandom_range(0, 300), rdy, cpl);
    end
    check("job_timeout", {63'd0, job_active || done_now}, 64'd0);
  endtask

  task automatic job(input logic [63:0] a, input int beats, input int rdy_pct, input int cpl_pct);
    int h0;
    h0 = n_hs;
    step(1'b1, a, 32'(beats), 1'b0, 1'b0);
    run_to_idle(rdy_pct, cpl_pct);
    check("burst_count", 64'(n_hs - h0), 64'((beats + BLEN - 1) / BLEN));
    $display("job addr=%016h beats=%0d bursts=%0d", a, beats, n_hs - h0);
  endtask

  int h0;
  logic [63:0] ra;

  initial begin
    rst = 1'b1; ctrl_start = 1'b0; ctrl_addr = '0; ctrl_xfer_beats = '0;
    req_ready = 1'b0; cpl_valid = 1'b0; n_hs = 0;
    do_reset();
    step(1'b0, '0, '0, 1'b0, 1'b0);

    job(64'h1000_0000, 256, 80, 50);
    job(64'h1000_0000, 100, 100, 60);
    job(64'h2000_0000, 0, 50, 50);
    job(64'hFFFF_FFFF_FFFF_E000, 256, 70, 40);

    // Throttle: two handshakes then stall until one completion.
    h0 = n_hs;
    step(1'b1, 64'h2000_0000, 32'd512, 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("throttle_hs", 64'(n_hs - h0), 64'd2);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("throttle_resume", 64'(n_hs - h0), 64'd3);
    run_to_idle(90, 50);
    $display("job throttle bursts=%0d", n_hs - h0);

    // Handshake and completion together at outstanding 1 keep the count at 1.
    h0 = n_hs;
    step(1'b1, 64'h3000_0000, 32'd256, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("same_cycle_hs", 64'(n_hs - h0), 64'd3);
    run_to_idle(90, 50);
    $display("job same-cycle bursts=%0d", n_hs - h0);

    // Spurious completion in IDLE must not disturb the counter.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    h0 = n_hs;
    step(1'b1, 64'h4000_0000, 32'd256, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("spurious_hs", 64'(n_hs - h0), 64'd2);
    run_to_idle(90, 50);
    $display("job spurious-cpl bursts=%0d", n_hs - h0);

    // Reset mid-ISSUE with req_valid high; completions after it are discarded.
    step(1'b1, 64'h5000_0000, 32'd512, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("pre_rst_valid", {63'd0, req_valid}, 64'd1);
    do_reset();
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    $display("reset mid-issue");
    job(64'h6000_0000, 64, 100, 100);

    for (int j = 0; j < 25; j++) begin
      ra = {$urandom(), $urandom()};
      ra[11:0] = 12'd0;
      job(ra, $urandom_range(0, 700), $urandom_range(20, 100), $urandom_range(10, 90));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
